// File: rtl/memory_stage_pkg.sv
// Shared types and encodings for the MEM stage: writeback control codes, FSM states, MEM_WB payload.
// No logic here; latency and backpressure belong to the modules that import it.
package memory_stage_pkg;

   localparam logic [1:0] WB_NONE = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_MEM  = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] mem_data;
      logic [31:0] alu1;
      logic [31:0] alu2;
      logic [4:0]  dest;
      logic [1:0]  wb;
      logic        addr_err;
   } mem_wb_t;

endpackage

// File: rtl/memory_stage_if.sv
// EXE_MEM inputs and MEM_WB outputs of the memory stage; slave = the stage itself.
// Pure wiring; stall is the only backpressure and flows back to the master side.
interface memory_stage_if;

   logic [31:0] PC_MEMORY;
   logic [31:0] result_ALU1_MEMORY;
   logic [31:0] result_ALU2_MEMORY;
   logic [31:0] store_value_MEMORY;
   logic [4:0]  destination_MEMORY;
   logic        MEMORY_READ_MEMORY;
   logic        MEMORY_WRITE_MEMORY;
   logic [1:0]  WRITEBACK_MEMORY;

   logic [31:0] result_forwarding_MEMORY;
   logic        memory_stall;
   logic [31:0] PC_WRITEBACK;
   logic [31:0] memory_data_WRITEBACK;
   logic [31:0] result_ALU1_WRITEBACK;
   logic [31:0] result_ALU2_WRITEBACK;
   logic [4:0]  destination_WRITEBACK;
   logic [1:0]  WRITEBACK_WRITEBACK;
   logic        address_error_WRITEBACK;

   modport slave (
      input  PC_MEMORY, result_ALU1_MEMORY, result_ALU2_MEMORY, store_value_MEMORY,
             destination_MEMORY, MEMORY_READ_MEMORY, MEMORY_WRITE_MEMORY, WRITEBACK_MEMORY,
      output result_forwarding_MEMORY, memory_stall, PC_WRITEBACK, memory_data_WRITEBACK,
             result_ALU1_WRITEBACK, result_ALU2_WRITEBACK, destination_WRITEBACK,
             WRITEBACK_WRITEBACK, address_error_WRITEBACK
   );

   modport master (
      output PC_MEMORY, result_ALU1_MEMORY, result_ALU2_MEMORY, store_value_MEMORY,
             destination_MEMORY, MEMORY_READ_MEMORY, MEMORY_WRITE_MEMORY, WRITEBACK_MEMORY,
      input  result_forwarding_MEMORY, memory_stall, PC_WRITEBACK, memory_data_WRITEBACK,
             result_ALU1_WRITEBACK, result_ALU2_WRITEBACK, destination_WRITEBACK,
             WRITEBACK_WRITEBACK, address_error_WRITEBACK
   );

endinterface

// File: rtl/memory_stage_mem_wb.sv
// MEM_WB pipeline register: 1-cycle, loads every edge; bubble=1 loads an all-zero (no writeback) entry.
// No backpressure of its own; the stage above decides when a bubble is inserted.
module memory_stage_mem_wb
   import memory_stage_pkg::*;
(
   input  logic    clock1,
   input  logic    reset,
   input  logic    bubble,
   input  mem_wb_t in_dat,
   output mem_wb_t out_dat
);

   mem_wb_t stage_d;
   mem_wb_t stage_q;

   always_comb begin
      stage_d = in_dat;
      if (bubble) begin
         stage_d    = '0;
         stage_d.wb = WB_NONE;
      end
   end

   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_dat = stage_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory load/store with MEM_LATENCY-cycle access, results registered into MEM_WB.
// Accesses with MEM_LATENCY>1 raise memory_stall until the completing edge; upstream must hold inputs.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int MEM_WORDS   = 256,
   parameter int MEM_LATENCY = 1
)
(
   input  logic          clock1,
   input  logic          reset,
   memory_stage_if.slave bus
);

   localparam int          IDX_W      = $clog2(MEM_WORDS);
   localparam int          CNT_W      = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   logic [31:0]      mem_q [MEM_WORDS];
   mem_state_t       state_d, state_q;
   logic [CNT_W-1:0] count_d, count_q;

   logic             access;
   logic             fault;
   logic             stall;
   logic             complete;
   logic             mem_we;
   logic [31:0]      addr;
   logic [IDX_W-1:0] index;
   mem_wb_t          wb_in;
   mem_wb_t          wb_out;

   assign addr   = bus.result_ALU1_MEMORY;
   assign index  = addr[IDX_W+1:2];
   assign access = bus.MEMORY_READ_MEMORY | bus.MEMORY_WRITE_MEMORY;
   assign fault  = (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT) ||
                   (bus.MEMORY_READ_MEMORY && bus.MEMORY_WRITE_MEMORY);

   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (access && (MEM_LATENCY > 1)) begin
               state_d = ST_BUSY;
               count_d = CNT_W'(MEM_LATENCY - 2);
            end
         end
         ST_BUSY: begin
            if (count_q != '0) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stall is gated by reset so it falls the instant reset rises, even with a held access.
   always_comb begin
      stall    = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               if (MEM_LATENCY == 1) begin
                  complete = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (count_q != '0) begin
               stall = 1'b1;
            end else begin
               complete = 1'b1;
            end
         end
         default: ;
      endcase
      if (reset) begin
         stall    = 1'b0;
         complete = 1'b0;
      end
   end

   assign mem_we = complete && bus.MEMORY_WRITE_MEMORY && !fault;

   always_ff @(posedge clock1) begin
      if (mem_we) begin
         mem_q[index] <= bus.store_value_MEMORY;
      end
   end

   always_comb begin
      wb_in          = '0;
      wb_in.pc       = bus.PC_MEMORY;
      wb_in.alu1     = bus.result_ALU1_MEMORY;
      wb_in.alu2     = bus.result_ALU2_MEMORY;
      wb_in.dest     = bus.destination_MEMORY;
      wb_in.wb       = bus.WRITEBACK_MEMORY;
      wb_in.addr_err = access && fault;
      wb_in.mem_data = (bus.MEMORY_READ_MEMORY && !fault) ? mem_q[index] : 32'h0;
   end

   memory_stage_mem_wb u_mem_wb (
      .clock1  (clock1),
      .reset   (reset),
      .bubble  (stall),
      .in_dat  (wb_in),
      .out_dat (wb_out)
   );

   assign bus.result_forwarding_MEMORY = bus.result_ALU1_MEMORY;
   assign bus.memory_stall             = stall;
   assign bus.PC_WRITEBACK             = wb_out.pc;
   assign bus.memory_data_WRITEBACK    = wb_out.mem_data;
   assign bus.result_ALU1_WRITEBACK    = wb_out.alu1;
   assign bus.result_ALU2_WRITEBACK    = wb_out.alu2;
   assign bus.destination_WRITEBACK    = wb_out.dest;
   assign bus.WRITEBACK_WRITEBACK      = wb_out.wb;
   assign bus.address_error_WRITEBACK  = wb_out.addr_err;

endmodule
